// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD add sequencer driving one shared single-digit BCD adder cell.
// Define BCD_SUB_EN to add the `sub` port (ten's-complement subtraction A - B).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_sum,
  input  logic                  add_carry
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_err;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_add_a;
  logic [3:0]       r_add_b;
  logic             r_add_cin;

  logic [W-1:0]     w_b_eff;
  logic             w_cin_eff;
  logic             w_bad;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

`ifdef BCD_SUB_EN
  function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    end
    return r;
  endfunction
`endif

  // Operand B / carry-in as seen by the adder chain; err always checks the raw operands.
  always_comb begin
`ifdef BCD_SUB_EN
    w_b_eff   = sub ? nines_comp(op_b) : op_b;
    w_cin_eff = sub | cin;
`else
    w_b_eff   = op_b;
    w_cin_eff = cin;
`endif
    w_bad = has_bad_digit(op_a) | has_bad_digit(op_b);
  end

  // r_a/r_b hold the not-yet-presented digits; r_add_cin doubles as the inter-digit carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_add_a   <= 4'd0;
      r_add_b   <= 4'd0;
      r_add_cin <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_a       <= op_a >> 4;
            r_b       <= w_b_eff >> 4;
            r_add_a   <= op_a[3:0];
            r_add_b   <= w_b_eff[3:0];
            r_add_cin <= w_cin_eff;
            r_err     <= w_bad;
            r_result  <= '0;
            r_cout    <= 1'b0;
          end
        end
        ST_RUN: begin
          r_result[4*r_idx +: 4] <= add_sum;
          r_idx <= r_idx + 1'b1;
          r_a   <= r_a >> 4;
          r_b   <= r_b >> 4;
          if (r_idx == LAST_IDX) begin
            r_cout    <= add_carry;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_add_a   <= 4'd0;
            r_add_b   <= 4'd0;
            r_add_cin <= 1'b0;
          end else begin
            r_add_a   <= r_a[3:0];
            r_add_b   <= r_b[3:0];
            r_add_cin <= add_carry;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign cout    = r_cout;
  assign err     = r_err;
  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign add_cin = r_add_cin;

endmodule
